branch_pc_unit: RTL and testbench

Program-counter and branch-resolution stage downstream of the 8-bit ALU. It consumes the ALU `zero` flag together with decoder branch controls and holds the registered PC that addresses instruction memory. Branch targets come from a small writable lookup table, loaded while the core is not running. The block also owns the core's start/done handshake and a run-cycle counter.

---
 rtl/branch_pc_unit.sv | 92 +++++++++
 tb/tb_branch_pc_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register, branch resolution, target LUT, start/done FSM and run-cycle counter (option: BRANCH_PC_RELATIVE_EN)
module branch_pc_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_on_zero,
  input  logic              alu_zero,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic              taken,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int LUT_N = 1 << LUT_AW;
  localparam logic [PC_W-1:0] PC_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic [PC_W-1:0]  lut_q [LUT_N];
  logic [PC_W-1:0]  target;
  logic [CNT_W-1:0] cnt_inc;
  logic             take;
`ifdef BRANCH_PC_RELATIVE_EN
  assign target = pc_q + lut_q[lut_idx];
`else
  assign target = lut_q[lut_idx];
`endif
  assign take    = branch_en && (alu_zero == branch_on_zero);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  // next-state: stall beats halt beats taken branch beats sequential fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    taken_d = 1'b0;
    if (state_q == RUN) begin
      if (!stall) begin
        cnt_d = cnt_inc;
        if (halt) state_d = DONE;
        else if (take) begin
          pc_d    = target;
          taken_d = 1'b1;
        end else pc_d = pc_q + PC_ONE;
      end
    end else if (start) begin
      state_d = RUN;
      pc_d    = '0;
      cnt_d   = '0;
    end
  end
  // state, PC, counter and taken pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end
  // target LUT; writes only land outside RUN so a running program sees a stable table
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else if (lut_we && state_q != RUN) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end
  assign pc          = pc_q;
  assign running     = state_q == RUN;
  assign done        = state_q == DONE;
  assign taken       = taken_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed vector table plus hand sequences for branch_pc_unit (CNT_W=4)
module tb_branch_pc_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 0, halt = 0, stall = 0, branch_en = 0, branch_on_zero = 0, alu_zero = 0, lut_we = 0;
  logic [3:0] lut_idx = 0, lut_waddr = 0;
  logic [9:0] lut_wdata = 0;
  logic [9:0] pc;
  logic running, done, taken;
  logic [3:0] cycle_count;
  int total = 0, bad = 0;

  branch_pc_unit #(.PC_W(10), .LUT_AW(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .branch_en(branch_en), .branch_on_zero(branch_on_zero), .alu_zero(alu_zero),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .running(running), .done(done), .taken(taken), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, ht, sl, be, boz, az;
    logic [3:0] idx;
    logic we;
    logic [3:0] wa;
    logic [9:0] wd;
    logic [9:0] epc;
    logic erun, edone, etak;
    logic [3:0] ecnt;
  } vec_t;
  vec_t tbl [19];

  function automatic logic [9:0] tgt(input logic [9:0] p, input logic [9:0] e);
`ifdef BRANCH_PC_RELATIVE_EN
    return p + e;
`else
    return e;
`endif
  endfunction

  function automatic vec_t mk(input logic st, ht, sl, be, boz, az, input logic [3:0] idx,
                              input logic we, input logic [3:0] wa, input logic [9:0] wd,
                              input logic [9:0] epc, input logic erun, edone, etak, input logic [3:0] ecnt);
    vec_t v;
    v.st = st; v.ht = ht; v.sl = sl; v.be = be; v.boz = boz; v.az = az; v.idx = idx;
    v.we = we; v.wa = wa; v.wd = wd; v.epc = epc; v.erun = erun; v.edone = edone; v.etak = etak; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; halt = 0; stall = 0; branch_en = 0; branch_on_zero = 0; alu_zero = 0;
    lut_idx = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic chk_all(input string n, input logic [9:0] p, input logic r, d, t, input logic [3:0] c);
    chk({n, ".pc"}, 32'(pc), 32'(p));
    chk({n, ".running"}, 32'(running), 32'(r));
    chk({n, ".done"}, 32'(done), 32'(d));
    chk({n, ".taken"}, 32'(taken), 32'(t));
    chk({n, ".cnt"}, 32'(cycle_count), 32'(c));
  endtask

  task automatic run_to(input logic [9:0] target, input int budget);
    int n = 0;
    while (pc !== target && n < budget) begin
      step();
      n++;
    end
    chk("reach_pc", 32'(pc), 32'(target));
  endtask

  initial begin
    logic [9:0] t1, t2, e;
    t1 = tgt(10'd5, 10'h120);
    t2 = tgt(t1 + 10'd1, 10'h120);
    //            st ht sl be boz az idx we wa wd      epc     run dn tk cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 10'h120, 10'd0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd0,  1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd1,  1, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd2,  1, 0, 0, 2);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd3,  1, 0, 0, 3);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd4,  1, 0, 0, 4);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd5,  1, 0, 0, 5);
    tbl[7]  = mk(0, 0, 0, 1, 1, 1, 3, 0, 0, 0,       t1,     1, 0, 1, 6);
    tbl[8]  = mk(0, 0, 0, 1, 1, 0, 3, 0, 0, 0,       t1 + 10'd1, 1, 0, 0, 7);
    tbl[9]  = mk(0, 0, 0, 1, 0, 0, 3, 0, 0, 0,       t2,     1, 0, 1, 8);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,       t2,     0, 1, 0, 9);
    tbl[11] = mk(0, 1, 1, 1, 1, 1, 3, 0, 0, 0,       t2,     0, 1, 0, 9);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd0,  1, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd1,  1, 0, 0, 1);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,       10'd1,  0, 1, 0, 2);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd0,  1, 0, 0, 0);
    tbl[16] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,       10'd0,  0, 1, 0, 1);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd0,  1, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       10'd1,  1, 0, 0, 1);

    reset = 1; start = 1; halt = 1; branch_en = 1; alu_zero = 1; branch_on_zero = 1;
    step();
    step();
    chk_all("reset", 10'd0, 0, 0, 0, 0);
    reset = 0;
    clr();

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].st; halt = tbl[i].ht; stall = tbl[i].sl; branch_en = tbl[i].be;
      branch_on_zero = tbl[i].boz; alu_zero = tbl[i].az; lut_idx = tbl[i].idx;
      lut_we = tbl[i].we; lut_waddr = tbl[i].wa; lut_wdata = tbl[i].wd;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].erun, tbl[i].edone, tbl[i].etak, tbl[i].ecnt);
    end
    clr();

    reset = 1; step(); reset = 0;
    start = 1; step(); start = 0;
    run_to(10'd5, 20);
    branch_en = 1; branch_on_zero = 1; alu_zero = 0; lut_idx = 3;
    step();
    chk_all("not_taken", 10'd6, 1, 0, 0, 6);
    clr();
    step();
    chk_all("to7", 10'd7, 1, 0, 0, 7);
    stall = 1; halt = 1;
    step();
    chk_all("stall_halt", 10'd7, 1, 0, 0, 7);
    stall = 0;
    step();
    chk_all("halt_release", 10'd7, 0, 1, 0, 8);
    clr();

    start = 1; step(); start = 0;
    lut_we = 1; lut_waddr = 2; lut_wdata = 10'h055;
    step();
    chk_all("we_in_run", 10'd1, 1, 0, 0, 1);
    lut_we = 0; halt = 1; step(); halt = 0;
    start = 1; step(); start = 0;
    step(); step();
    chk("pc2", 32'(pc), 32'd2);
    branch_en = 1; branch_on_zero = 1; alu_zero = 1; lut_idx = 2;
    step();
    chk_all("dropped_write", tgt(10'd2, 10'd0), 1, 0, 1, 3);
    clr();
    step();
    chk_all("taken_pulse_end", tgt(10'd2, 10'd0) + 10'd1, 1, 0, 0, 4);

    halt = 1; step(); halt = 0;
    start = 1; step(); start = 0;
    run_to(10'h040, 100);
    chk("cnt_sat", 32'(cycle_count), 32'd15);
    reset = 1; start = 1;
    step();
    chk_all("reset_mid_run", 10'd0, 0, 0, 0, 0);
    reset = 0; start = 0;

    lut_we = 1; lut_waddr = 1; lut_wdata = 10'h3FE; step(); lut_we = 0;
    start = 1; step(); start = 0;
    step();
    chk("pc1", 32'(pc), 32'd1);
    branch_en = 1; branch_on_zero = 0; alu_zero = 0; lut_idx = 1;
    step();
    e = tgt(10'd1, 10'h3FE);
    chk_all("br_3fe", e, 1, 0, 1, 2);
    clr();
    step();
    e = e + 10'd1;
    chk_all("wrap1", e, 1, 0, 0, 3);
    step();
    e = e + 10'd1;
    chk_all("wrap2", e, 1, 0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
